// File: rtl/video_chk_pkg.sv
// Shared constants, types and the CRC-32 step function for the video frame checker.
package video_chk_pkg;

    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    // Widest pixel word crc32_step can consume in one call.
    localparam int unsigned CRC_MAX_W = 256;

    // Error flag bit positions.
    localparam int ERR_H    = 0;
    localparam int ERR_V    = 1;
    localparam int ERR_SYNC = 2;
    localparam int ERR_OVF  = 3;

    typedef enum logic {
        CHK_UNARMED,
        CHK_ARMED
    } chk_state_t;

    // MSB-first CRC-32 over the low 'width' bits of 'word'. No reflection, no final XOR.
    function automatic logic [31:0] crc32_step(
        input logic [31:0]          crc,
        input logic [CRC_MAX_W-1:0] word,
        input int unsigned          width
    );
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int unsigned k = 0; k < CRC_MAX_W; k++) begin
            if (k < width) begin
                fb = c[31] ^ word[width-1-k];
                c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vid_sync_edge.sv
// Registers VS/HS/DE once, normalises sync polarity and derives edge strobes
// from the registered versus previous-registered samples.
module vid_sync_edge #(
    parameter bit VS_POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic hsync,
    input  logic de,
    output logic vs_act,
    output logic hs_act,
    output logic de_act,
    output logic vs_rise,
    output logic de_fall
);

    logic vs_prev;
    logic de_prev;

    // Sample pins (sync levels normalised to active-high) and keep previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_act  <= 1'b0;
            hs_act  <= 1'b0;
            de_act  <= 1'b0;
            vs_prev <= 1'b0;
            de_prev <= 1'b0;
        end else begin
            vs_act  <= (vsync == VS_POL);
            hs_act  <= (hsync == VS_POL);
            de_act  <= de;
            vs_prev <= vs_act;
            de_prev <= de_act;
        end
    end

    // Edge strobes, valid for the cycle the registered sample shows the change.
    always_comb begin
        vs_rise = vs_act & ~vs_prev;
        de_fall = ~de_act & de_prev;
    end

endmodule

// File: rtl/video_frame_checker.sv
// Per-frame geometry, channel-sum and CRC-32 monitor for a VS/HS/DE pixel stream.
module video_frame_checker
    import video_chk_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 3,
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int CNT_W    = 12,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                     I_PCLK,
    input  logic                     I_RST,
    input  logic [NUM_CH*DATA_W-1:0] I_PIX_DATA,
    input  logic                     I_VSYNC,
    input  logic                     I_HSYNC,
    input  logic                     I_DE,
    output logic                     O_FRAME_DONE,
    output logic [CNT_W-1:0]         O_MEAS_H,
    output logic [CNT_W-1:0]         O_MEAS_V,
    output logic [NUM_CH*32-1:0]     O_CH_SUM,
    output logic [31:0]              O_CRC,
    output logic [3:0]               O_ERR,
    output logic [15:0]              O_FRAME_CNT
);

    localparam int unsigned      PIX_W   = NUM_CH * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic vs_act, hs_act, de_act, vs_rise, de_fall;

    vid_sync_edge #(
        .VS_POL (VS_POL)
    ) u_sync (
        .clk     (I_PCLK),
        .rst     (I_RST),
        .vsync   (I_VSYNC),
        .hsync   (I_HSYNC),
        .de      (I_DE),
        .vs_act  (vs_act),
        .hs_act  (hs_act),
        .de_act  (de_act),
        .vs_rise (vs_rise),
        .de_fall (de_fall)
    );

    // Channel 0 sits in the top element, matching the pin and sum layouts.
    logic [NUM_CH-1:0][DATA_W-1:0] pix_q;

    chk_state_t              state_q;
    logic                    line_open_q;
    logic [CNT_W-1:0]        pix_cnt_q, line_cnt_q, last_w_q;
    logic [NUM_CH-1:0][31:0] sum_q;
    logic [31:0]             crc_q;
    logic [3:0]              err_q;

    logic                    armed;
    logic                    close_line;
    logic                    line_open_nx;
    logic [CNT_W-1:0]        pix_cnt_nx, line_cnt_nx, last_w_nx;
    logic [NUM_CH-1:0][31:0] sum_nx;
    logic [31:0]             crc_nx;
    logic [3:0]              err_nx;
    logic [3:0]              err_fin;

    // Next accumulator values including this cycle's pixel and any line close;
    // at a VS edge these are what gets reported, so a line ending on the same
    // sample (or still open at the edge) belongs to the finishing frame.
    always_comb begin
        armed        = (state_q == CHK_ARMED);
        line_open_nx = line_open_q;
        pix_cnt_nx   = pix_cnt_q;
        line_cnt_nx  = line_cnt_q;
        last_w_nx    = last_w_q;
        sum_nx       = sum_q;
        crc_nx       = crc_q;
        err_nx       = err_q;
        close_line   = 1'b0;

        if (armed) begin
            if (de_act) begin
                line_open_nx = 1'b1;
                if (pix_cnt_q == CNT_MAX) begin
                    err_nx[ERR_OVF] = 1'b1;
                end else begin
                    pix_cnt_nx = pix_cnt_q + 1'b1;
                end
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    sum_nx[i] = sum_q[i] + 32'(pix_q[i]);
                end
                crc_nx = crc32_step(crc_q, CRC_MAX_W'(pix_q), PIX_W);
                if (vs_act || hs_act) begin
                    err_nx[ERR_SYNC] = 1'b1;
                end
            end

            // A fall only closes a line that actually counted pixels.
            close_line = (de_fall && line_open_q) || (vs_rise && de_act);
            if (close_line) begin
                last_w_nx    = pix_cnt_nx;
                line_open_nx = 1'b0;
                if (pix_cnt_nx != CNT_W'(H_PIXELS)) begin
                    err_nx[ERR_H] = 1'b1;
                end
                if (line_cnt_q == CNT_MAX) begin
                    err_nx[ERR_OVF] = 1'b1;
                end else begin
                    line_cnt_nx = line_cnt_q + 1'b1;
                end
                pix_cnt_nx = '0;
            end
        end

        err_fin = err_nx;
        if (line_cnt_nx != CNT_W'(V_LINES)) begin
            err_fin[ERR_V] = 1'b1;
        end
    end

    // Accumulate, arm on first VS edge, finalize and restart on later edges.
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            pix_q        <= '0;
            state_q      <= CHK_UNARMED;
            line_open_q  <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            last_w_q     <= '0;
            sum_q        <= '0;
            crc_q        <= CRC_INIT;
            err_q        <= '0;
            O_FRAME_DONE <= 1'b0;
            O_MEAS_H     <= '0;
            O_MEAS_V     <= '0;
            O_CH_SUM     <= '0;
            O_CRC        <= '0;
            O_ERR        <= '0;
            O_FRAME_CNT  <= '0;
        end else begin
            pix_q        <= I_PIX_DATA;
            O_FRAME_DONE <= 1'b0;
            if (vs_rise) begin
                state_q     <= CHK_ARMED;
                line_open_q <= 1'b0;
                pix_cnt_q   <= '0;
                line_cnt_q  <= '0;
                last_w_q    <= '0;
                sum_q       <= '0;
                crc_q       <= CRC_INIT;
                err_q       <= '0;
                if (armed) begin
                    O_FRAME_DONE <= 1'b1;
                    O_MEAS_H     <= last_w_nx;
                    O_MEAS_V     <= line_cnt_nx;
                    O_CH_SUM     <= sum_nx;
                    O_CRC        <= crc_nx;
                    O_ERR        <= err_fin;
                    O_FRAME_CNT  <= O_FRAME_CNT + 16'd1;
                end
            end else begin
                line_open_q <= line_open_nx;
                pix_cnt_q   <= pix_cnt_nx;
                line_cnt_q  <= line_cnt_nx;
                last_w_q    <= last_w_nx;
                sum_q       <= sum_nx;
                crc_q       <= crc_nx;
                err_q       <= err_nx;
            end
        end
    end

endmodule

// File: tb/tb_video_frame_checker.sv
// Directed/random frame sequences against a frame-level reference model.
module tb_video_frame_checker;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int CMAX = 4095;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pix_data;
    logic        vsync, hsync, de;
    logic        frame_done;
    logic [11:0] meas_h, meas_v;
    logic [95:0] ch_sum;
    logic [31:0] crc;
    logic [3:0]  err;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    video_frame_checker #(
        .DATA_W   (8),
        .NUM_CH   (3),
        .H_PIXELS (H),
        .V_LINES  (V),
        .CNT_W    (12),
        .VS_POL   (1'b1)
    ) dut (
        .I_PCLK       (clk),
        .I_RST        (rst),
        .I_PIX_DATA   (pix_data),
        .I_VSYNC      (vsync),
        .I_HSYNC      (hsync),
        .I_DE         (de),
        .O_FRAME_DONE (frame_done),
        .O_MEAS_H     (meas_h),
        .O_MEAS_V     (meas_v),
        .O_CH_SUM     (ch_sum),
        .O_CRC        (crc),
        .O_ERR        (err),
        .O_FRAME_CNT  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic [95:0] sums;
        logic [31:0] crc;
        logic [3:0]  err;
    } exp_t;

    // Reference model: the frame as a list of line lengths plus running sums/CRC.
    int unsigned lines[$];
    logic [31:0] m_sum [3];
    logic [31:0] m_crc;
    bit          m_sync;
    bit          m_armed;
    int          exp_fc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Same CRC as bitwise MSB-first, formulated as XOR-in-word then long division.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [23:0] w);
        logic [31:0] r;
        r = c ^ {w, 8'h00};
        for (int i = 0; i < 24; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    task automatic model_clear();
        lines.delete();
        for (int c = 0; c < 3; c++) m_sum[c] = 32'd0;
        m_crc  = 32'hFFFF_FFFF;
        m_sync = 1'b0;
    endtask

    task automatic model_pixel(input logic [23:0] px);
        for (int c = 0; c < 3; c++) m_sum[c] = m_sum[c] + 32'((px >> (8 * (2 - c))) & 24'hFF);
        m_crc = ref_crc(m_crc, px);
    endtask

    function automatic exp_t model_final();
        exp_t e;
        int unsigned n, last, sl;
        bit e0, e3;
        n  = lines.size();
        last = (n > 0) ? lines[n-1] : 0;
        e0 = 1'b0;
        e3 = (n > CMAX);
        foreach (lines[i]) begin
            sl = (lines[i] > CMAX) ? CMAX : lines[i];
            if (sl != H) e0 = 1'b1;
            if (lines[i] > CMAX) e3 = 1'b1;
        end
        e.h    = 12'((last > CMAX) ? CMAX : last);
        e.v    = 12'((n > CMAX) ? CMAX : n);
        e.sums = {m_sum[0], m_sum[1], m_sum[2]};
        e.crc  = m_crc;
        e.err  = {e3, m_sync, (int'(e.v) != V), e0};
        return e;
    endfunction

    task automatic cyc(input logic v, input logic h, input logic d, input logic [23:0] px);
        vsync = v; hsync = h; de = d; pix_data = px;
        @(negedge clk);
    endtask

    function automatic logic [23:0] pixel_of(input int mode, input int l, input int c, input bit dmod);
        logic [23:0] p;
        case (mode)
            0:       p = 24'h010203;
            1:       p = {8'(l), 8'(c), 8'(l + c)};
            default: p = 24'($urandom);
        endcase
        if (dmod && l == 3 && c == 5) p = p ^ 24'h102030;
        return p;
    endfunction

    task automatic send_line(input int len, input bit blank, input int mode, input int l, input bit dmod);
        logic [23:0] px;
        for (int c = 0; c < len; c++) begin
            px = pixel_of(mode, l, c, dmod);
            model_pixel(px);
            cyc(1'b0, 1'b0, 1'b1, px);
        end
        lines.push_back(len);
        if (blank) begin
            cyc(1'b0, 1'b0, 1'b0, 24'h0);
            cyc(1'b0, 1'b1, 1'b0, 24'h0);
            cyc(1'b0, 1'b1, 1'b0, 24'h0);
            cyc(1'b0, 1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic send_body(input int nl, input int mode, input int odd_l, input int odd_len,
                             input bit last_blank, input bit dmod);
        for (int l = 0; l < nl; l++)
            send_line((l == odd_l) ? odd_len : H, (l == nl - 1) ? last_blank : 1'b1, mode, l, dmod);
    endtask

    // VS pulse: checks done pulse latency and reported results of the finishing frame.
    task automatic do_vs(input bit de_at_edge, input bit de_in_vs);
        exp_t        snap;
        bit          expect_done;
        logic [23:0] px;
        expect_done = m_armed;
        if (de_at_edge) begin
            px = 24'($urandom);
            model_pixel(px);
            lines[lines.size()-1] = lines[lines.size()-1] + 1;
            m_sync = 1'b1;
            cyc(1'b1, 1'b0, 1'b1, px);
        end else begin
            cyc(1'b1, 1'b0, 1'b0, 24'h0);
        end
        snap = model_final();
        model_clear();
        m_armed = 1'b1;
        chk("done_early", frame_done, 1'b0);
        chk("cnt_hold", frame_cnt, 16'(exp_fc));
        for (int k = 0; k < 2; k++) begin
            if (de_in_vs) begin
                px = 24'($urandom);
                model_pixel(px);
                m_sync = 1'b1;
                cyc(1'b1, 1'b0, 1'b1, px);
            end else begin
                cyc(1'b1, 1'b0, 1'b0, 24'h0);
            end
            if (k == 0) begin
                chk("done_pulse", frame_done, expect_done);
                if (expect_done) begin
                    exp_fc++;
                    chk("meas_h", meas_h, snap.h);
                    chk("meas_v", meas_v, snap.v);
                    chk("ch_sum", ch_sum, snap.sums);
                    chk("crc", crc, snap.crc);
                    chk("err", err, snap.err);
                    chk("frame_cnt", frame_cnt, 16'(exp_fc));
                end
            end
        end
        chk("done_late", frame_done, 1'b0);
        if (de_in_vs) lines.push_back(2);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_done", frame_done, 1'b0);
        chk("rst_h", meas_h, 12'd0);
        chk("rst_v", meas_v, 12'd0);
        chk("rst_sum", ch_sum, 96'd0);
        chk("rst_crc", crc, 32'd0);
        chk("rst_err", err, 4'd0);
        chk("rst_cnt", frame_cnt, 16'd0);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0; pix_data = 24'h0;
        m_armed = 1'b0; exp_fc = 0;
        model_clear();
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 24'h0);

        do_vs(1'b0, 1'b0);                       // arms only
        send_body(V, 0, -1, 0, 1'b1, 1'b0);      // constant pixel
        do_vs(1'b0, 1'b0);
        chk("const_sum", ch_sum, {32'd128, 32'd256, 32'd384});
        chk("const_err", err, 4'b0000);

        send_body(V, 1, -1, 0, 1'b1, 1'b0);      // ramp
        do_vs(1'b0, 1'b0);
        send_body(V, 1, -1, 0, 1'b1, 1'b0);      // identical ramp
        do_vs(1'b0, 1'b0);
        send_body(V, 1, -1, 0, 1'b1, 1'b1);      // ramp with one pixel changed
        do_vs(1'b0, 1'b0);

        send_body(V, 0, 2, H - 1, 1'b1, 1'b0);   // one short line
        do_vs(1'b0, 1'b0);
        chk("short_err", err, 4'b0001);
        chk("short_v", meas_v, 12'd8);

        send_body(V, 2, -1, 0, 1'b0, 1'b0);      // random, last DE fall meets VS edge
        do_vs(1'b0, 1'b0);
        chk("clean_err", err, 4'b0000);

        send_body(V - 1, 2, -1, 0, 1'b1, 1'b0);  // one line missing
        do_vs(1'b0, 1'b1);                       // DE asserted inside VS for next frame
        chk("vlines_err", err, 4'b0010);
        send_body(V, 2, -1, 0, 1'b1, 1'b0);
        do_vs(1'b0, 1'b0);
        chk("sync_err", err, 4'b0111);

        send_body(1, 2, 0, 5000, 1'b1, 1'b0);    // overlong line saturates counter
        do_vs(1'b0, 1'b0);
        chk("ovf_err", err, 4'b1011);
        chk("ovf_h", meas_h, 12'hFFF);

        send_body(V, 2, -1, 0, 1'b0, 1'b0);      // DE still high at VS edge
        do_vs(1'b1, 1'b0);
        chk("de_edge_err", err, 4'b0101);
        send_body(V, 2, -1, 0, 1'b1, 1'b0);
        do_vs(1'b0, 1'b0);
        chk("recover_err", err, 4'b0000);

        send_body(2, 2, -1, 0, 1'b1, 1'b0);      // partial frame, then reset
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        chk_reset_outputs();
        rst = 1'b0;
        model_clear();
        m_armed = 1'b0;
        exp_fc = 0;
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        do_vs(1'b0, 1'b0);
        send_body(V, 2, -1, 0, 1'b1, 1'b0);
        do_vs(1'b0, 1'b0);
        chk("post_rst_cnt", frame_cnt, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
